bp_cache_lce_port: RTL and testbench

// Cache-side endpoint of the cache<->LCE service interface; sits inside each L1 cache opposite bp_lce.
// On a pipeline miss, drives cache_req (ready->valid), then metadata, then stalls the pipeline until the LCE signals completion.

---
 rtl/bp_cache_lce_port.sv | 186 ++++++++++++++++++
 tb/tb_bp_cache_lce_port.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cache_lce_port.sv
// Cache-side endpoint of the cache<->LCE service interface.
// A pipeline miss is sequenced as a request (ready->valid), then one metadata
// beat, then a stall until the LCE reports the miss resolved. Independently,
// LCE data/tag/stat packets are granted whenever the pipeline leaves the
// matching array idle. The array's read data is captured on the following
// cycle and held until the next read.
module bp_cache_lce_port #(
    parameter int req_width_p      = 8,
    parameter int meta_width_p     = 8,
    parameter int data_pkt_width_p = 8,
    parameter int tag_pkt_width_p  = 8,
    parameter int stat_pkt_width_p = 8,
    parameter int data_width_p     = 8,
    parameter int tag_width_p      = 8,
    parameter int stat_width_p     = 8,
    parameter int wd_limit_p       = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    // pipeline miss interface
    input  logic                        miss_v_i,
    input  logic [req_width_p-1:0]      miss_req_i,
    input  logic [meta_width_p-1:0]     miss_meta_i,
    output logic                        stall_o,
    // request / metadata toward the LCE
    output logic                        cache_req_v_o,
    output logic [req_width_p-1:0]      cache_req_o,
    input  logic                        cache_req_ready_i,
    output logic                        cache_req_metadata_v_o,
    output logic [meta_width_p-1:0]     cache_req_metadata_o,
    input  logic                        cache_req_complete_i,
    // data array channel
    input  logic                        data_mem_pkt_v_i,
    input  logic [data_pkt_width_p-1:0] data_mem_pkt_i,
    output logic                        data_mem_pkt_yumi_o,
    input  logic                        data_pipe_busy_i,
    output logic                        data_array_v_o,
    output logic [data_pkt_width_p-1:0] data_array_pkt_o,
    input  logic [data_width_p-1:0]     data_array_rdata_i,
    output logic [data_width_p-1:0]     data_mem_o,
    // tag array channel
    input  logic                        tag_mem_pkt_v_i,
    input  logic [tag_pkt_width_p-1:0]  tag_mem_pkt_i,
    output logic                        tag_mem_pkt_yumi_o,
    input  logic                        tag_pipe_busy_i,
    output logic                        tag_array_v_o,
    output logic [tag_pkt_width_p-1:0]  tag_array_pkt_o,
    input  logic [tag_width_p-1:0]      tag_array_rdata_i,
    output logic [tag_width_p-1:0]      tag_mem_o,
    // stat array channel
    input  logic                        stat_mem_pkt_v_i,
    input  logic [stat_pkt_width_p-1:0] stat_mem_pkt_i,
    output logic                        stat_mem_pkt_yumi_o,
    input  logic                        stat_pipe_busy_i,
    output logic                        stat_array_v_o,
    output logic [stat_pkt_width_p-1:0] stat_array_pkt_o,
    input  logic [stat_width_p-1:0]     stat_array_rdata_i,
    output logic [stat_width_p-1:0]     stat_mem_o,
    // sticky starvation flag
    output logic                        watchdog_o
);

    localparam int wd_cnt_width_lp = $clog2(wd_limit_p + 1);
    localparam logic [wd_cnt_width_lp-1:0] wd_limit_lp = wd_cnt_width_lp'(wd_limit_p);

    typedef enum logic [1:0] {
        e_ready     = 2'd0,
        e_send_req  = 2'd1,
        e_send_meta = 2'd2,
        e_wait      = 2'd3
    } state_e;

    state_e                     state_r;
    logic [req_width_p-1:0]     req_r;
    logic [meta_width_p-1:0]    meta_r;
    logic                       first_r;
    logic [wd_cnt_width_lp-1:0] wd_cnt_r;
    logic                       watchdog_r;
    logic                       data_rd_pend_r;
    logic                       tag_rd_pend_r;
    logic                       stat_rd_pend_r;
    logic [data_width_p-1:0]    data_mem_r;
    logic [tag_width_p-1:0]     tag_mem_r;
    logic [stat_width_p-1:0]    stat_mem_r;

    // Valid is only raised once ready is seen, so valid alone implies a fire.
    // Stall follows the registered state; it drops in the completing WAIT cycle.
    assign cache_req_v_o          = (state_r == e_send_req) & cache_req_ready_i;
    assign cache_req_o            = req_r;
    assign cache_req_metadata_v_o = (state_r == e_send_meta);
    assign cache_req_metadata_o   = meta_r;
    assign stall_o                = (state_r != e_ready)
                                  & ~((state_r == e_wait) & cache_req_complete_i);
    assign watchdog_o             = watchdog_r;

    // Array grants: each channel is served whenever its array is idle.
    assign data_mem_pkt_yumi_o = data_mem_pkt_v_i & ~data_pipe_busy_i;
    assign data_array_v_o      = data_mem_pkt_yumi_o;
    assign data_array_pkt_o    = data_mem_pkt_i;
    assign tag_mem_pkt_yumi_o  = tag_mem_pkt_v_i & ~tag_pipe_busy_i;
    assign tag_array_v_o       = tag_mem_pkt_yumi_o;
    assign tag_array_pkt_o     = tag_mem_pkt_i;
    assign stat_mem_pkt_yumi_o = stat_mem_pkt_v_i & ~stat_pipe_busy_i;
    assign stat_array_v_o      = stat_mem_pkt_yumi_o;
    assign stat_array_pkt_o    = stat_mem_pkt_i;
    assign data_mem_o          = data_mem_r;
    assign tag_mem_o           = tag_mem_r;
    assign stat_mem_o          = stat_mem_r;

    // Miss sequencer: request, metadata, wait for completion, with WAIT watchdog.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= e_ready;
            req_r      <= '0;
            meta_r     <= '0;
            first_r    <= 1'b0;
            wd_cnt_r   <= '0;
            watchdog_r <= 1'b0;
        end else begin
            case (state_r)
                e_ready: begin
                    if (miss_v_i) begin
                        req_r   <= miss_req_i;
                        first_r <= 1'b1;
                        state_r <= e_send_req;
                    end
                end
                e_send_req: begin
                    // metadata arrives one cycle after the miss pulse
                    if (first_r) begin
                        meta_r  <= miss_meta_i;
                        first_r <= 1'b0;
                    end
                    if (cache_req_ready_i) begin
                        state_r <= e_send_meta;
                    end
                end
                e_send_meta: begin
                    state_r <= cache_req_complete_i ? e_ready : e_wait;
                end
                e_wait: begin
                    if (cache_req_complete_i) begin
                        state_r  <= e_ready;
                        wd_cnt_r <= '0;
                    end else begin
                        if (wd_cnt_r != wd_limit_lp) begin
                            wd_cnt_r <= wd_cnt_r + wd_cnt_width_lp'(1);
                        end
                        if (wd_cnt_r >= (wd_limit_lp - wd_cnt_width_lp'(1))) begin
                            watchdog_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= e_ready;
                end
            endcase
        end
    end

    // Read capture: one cycle after a grant the array data is latched and held.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_rd_pend_r <= 1'b0;
            tag_rd_pend_r  <= 1'b0;
            stat_rd_pend_r <= 1'b0;
            data_mem_r     <= '0;
            tag_mem_r      <= '0;
            stat_mem_r     <= '0;
        end else begin
            data_rd_pend_r <= data_mem_pkt_yumi_o;
            tag_rd_pend_r  <= tag_mem_pkt_yumi_o;
            stat_rd_pend_r <= stat_mem_pkt_yumi_o;
            if (data_rd_pend_r) begin
                data_mem_r <= data_array_rdata_i;
            end
            if (tag_rd_pend_r) begin
                tag_mem_r <= tag_array_rdata_i;
            end
            if (stat_rd_pend_r) begin
                stat_mem_r <= stat_array_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_bp_cache_lce_port.sv
// Bench for bp_cache_lce_port: directed scenarios followed by a random phase,
// all checked every cycle against a transaction-level reference model.
module tb_bp_cache_lce_port;

    localparam int WD = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        miss_v_i;
    logic [15:0] miss_req_i;
    logic [11:0] miss_meta_i;
    logic        stall_o;
    logic        cache_req_v_o;
    logic [15:0] cache_req_o;
    logic        cache_req_ready_i;
    logic        cache_req_metadata_v_o;
    logic [11:0] cache_req_metadata_o;
    logic        cache_req_complete_i;
    logic        data_mem_pkt_v_i, data_mem_pkt_yumi_o, data_pipe_busy_i, data_array_v_o;
    logic [9:0]  data_mem_pkt_i, data_array_pkt_o;
    logic [31:0] data_array_rdata_i, data_mem_o;
    logic        tag_mem_pkt_v_i, tag_mem_pkt_yumi_o, tag_pipe_busy_i, tag_array_v_o;
    logic [7:0]  tag_mem_pkt_i, tag_array_pkt_o;
    logic [15:0] tag_array_rdata_i, tag_mem_o;
    logic        stat_mem_pkt_v_i, stat_mem_pkt_yumi_o, stat_pipe_busy_i, stat_array_v_o;
    logic [5:0]  stat_mem_pkt_i, stat_array_pkt_o;
    logic [7:0]  stat_array_rdata_i, stat_mem_o;
    logic        watchdog_o;

    int checks = 0;
    int failures = 0;

    // reference model: one outstanding miss described by its progress flags
    bit          m_active, m_first, m_req_sent, m_meta_sent, m_wd;
    int          m_wc;
    logic [15:0] m_req;
    logic [11:0] m_meta;
    logic [31:0] m_mem [3];
    bit          m_pend [3];

    bp_cache_lce_port #(
        .req_width_p(16), .meta_width_p(12),
        .data_pkt_width_p(10), .tag_pkt_width_p(8), .stat_pkt_width_p(6),
        .data_width_p(32), .tag_width_p(16), .stat_width_p(8),
        .wd_limit_p(WD)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .miss_v_i(miss_v_i), .miss_req_i(miss_req_i), .miss_meta_i(miss_meta_i),
        .stall_o(stall_o),
        .cache_req_v_o(cache_req_v_o), .cache_req_o(cache_req_o),
        .cache_req_ready_i(cache_req_ready_i),
        .cache_req_metadata_v_o(cache_req_metadata_v_o),
        .cache_req_metadata_o(cache_req_metadata_o),
        .cache_req_complete_i(cache_req_complete_i),
        .data_mem_pkt_v_i(data_mem_pkt_v_i), .data_mem_pkt_i(data_mem_pkt_i),
        .data_mem_pkt_yumi_o(data_mem_pkt_yumi_o), .data_pipe_busy_i(data_pipe_busy_i),
        .data_array_v_o(data_array_v_o), .data_array_pkt_o(data_array_pkt_o),
        .data_array_rdata_i(data_array_rdata_i), .data_mem_o(data_mem_o),
        .tag_mem_pkt_v_i(tag_mem_pkt_v_i), .tag_mem_pkt_i(tag_mem_pkt_i),
        .tag_mem_pkt_yumi_o(tag_mem_pkt_yumi_o), .tag_pipe_busy_i(tag_pipe_busy_i),
        .tag_array_v_o(tag_array_v_o), .tag_array_pkt_o(tag_array_pkt_o),
        .tag_array_rdata_i(tag_array_rdata_i), .tag_mem_o(tag_mem_o),
        .stat_mem_pkt_v_i(stat_mem_pkt_v_i), .stat_mem_pkt_i(stat_mem_pkt_i),
        .stat_mem_pkt_yumi_o(stat_mem_pkt_yumi_o), .stat_pipe_busy_i(stat_pipe_busy_i),
        .stat_array_v_o(stat_array_v_o), .stat_array_pkt_o(stat_array_pkt_o),
        .stat_array_rdata_i(stat_array_rdata_i), .stat_mem_o(stat_mem_o),
        .watchdog_o(watchdog_o)
    );

    // free-running clock, period 10
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_first = 1'b0; m_req_sent = 1'b0; m_meta_sent = 1'b0;
        m_wd = 1'b0; m_wc = 0;
        for (int c = 0; c < 3; c++) begin
            m_mem[c] = 32'd0;
            m_pend[c] = 1'b0;
        end
    endtask

    task automatic randomize_payloads();
        miss_req_i         = 16'($urandom);
        miss_meta_i        = 12'($urandom);
        data_mem_pkt_i     = 10'($urandom);
        tag_mem_pkt_i      = 8'($urandom);
        stat_mem_pkt_i     = 6'($urandom);
        data_array_rdata_i = 32'($urandom);
        tag_array_rdata_i  = 16'($urandom);
        stat_array_rdata_i = 8'($urandom);
    endtask

    // compare every output against the model, then advance one clock
    task automatic cycle();
        bit exp_req_v, exp_meta_v, exp_stall;
        bit pv [3];
        bit bz [3];
        bit yumi [3];
        pv[0] = data_mem_pkt_v_i; pv[1] = tag_mem_pkt_v_i; pv[2] = stat_mem_pkt_v_i;
        bz[0] = data_pipe_busy_i; bz[1] = tag_pipe_busy_i; bz[2] = stat_pipe_busy_i;
        for (int c = 0; c < 3; c++) yumi[c] = pv[c] & ~bz[c];
        #1;
        exp_req_v  = m_active & ~m_req_sent & cache_req_ready_i;
        exp_meta_v = m_active & m_req_sent & ~m_meta_sent;
        exp_stall  = m_active & ~(m_meta_sent & cache_req_complete_i);
        chk("stall", 64'(stall_o), 64'(exp_stall));
        chk("req_v", 64'(cache_req_v_o), 64'(exp_req_v));
        if (exp_req_v) chk("req_pkt", 64'(cache_req_o), 64'(m_req));
        chk("meta_v", 64'(cache_req_metadata_v_o), 64'(exp_meta_v));
        if (exp_meta_v) chk("meta_pkt", 64'(cache_req_metadata_o), 64'(m_meta));
        chk("watchdog", 64'(watchdog_o), 64'(m_wd));
        chk("data_yumi", 64'(data_mem_pkt_yumi_o), 64'(yumi[0]));
        chk("tag_yumi", 64'(tag_mem_pkt_yumi_o), 64'(yumi[1]));
        chk("stat_yumi", 64'(stat_mem_pkt_yumi_o), 64'(yumi[2]));
        chk("data_arr_v", 64'(data_array_v_o), 64'(yumi[0]));
        chk("tag_arr_v", 64'(tag_array_v_o), 64'(yumi[1]));
        chk("stat_arr_v", 64'(stat_array_v_o), 64'(yumi[2]));
        if (yumi[0]) chk("data_arr_pkt", 64'(data_array_pkt_o), 64'(data_mem_pkt_i));
        if (yumi[1]) chk("tag_arr_pkt", 64'(tag_array_pkt_o), 64'(tag_mem_pkt_i));
        if (yumi[2]) chk("stat_arr_pkt", 64'(stat_array_pkt_o), 64'(stat_mem_pkt_i));
        chk("data_mem", 64'(data_mem_o), 64'(m_mem[0]));
        chk("tag_mem", 64'(tag_mem_o), 64'(m_mem[1]));
        chk("stat_mem", 64'(stat_mem_o), 64'(m_mem[2]));
        @(posedge clk_i);
        // read return: data of the cycle after a grant becomes the held value
        if (m_pend[0]) m_mem[0] = data_array_rdata_i;
        if (m_pend[1]) m_mem[1] = 32'(tag_array_rdata_i);
        if (m_pend[2]) m_mem[2] = 32'(stat_array_rdata_i);
        for (int c = 0; c < 3; c++) m_pend[c] = yumi[c];
        // miss progress
        if (!m_active) begin
            if (miss_v_i) begin
                m_active = 1'b1; m_first = 1'b1; m_req = miss_req_i;
                m_req_sent = 1'b0; m_meta_sent = 1'b0;
            end
        end else begin
            if (m_first) begin
                m_meta = miss_meta_i;
                m_first = 1'b0;
            end
            if (!m_req_sent) begin
                if (cache_req_ready_i) m_req_sent = 1'b1;
            end else if (!m_meta_sent) begin
                m_meta_sent = 1'b1;
                if (cache_req_complete_i) m_active = 1'b0;
            end else if (cache_req_complete_i) begin
                m_active = 1'b0;
                m_wc = 0;
            end else begin
                m_wc++;
                if (m_wc >= WD) m_wd = 1'b1;
            end
        end
        #1;
        randomize_payloads();
    endtask

    task automatic ctrl_idle();
        miss_v_i = 1'b0; cache_req_ready_i = 1'b0; cache_req_complete_i = 1'b0;
        data_mem_pkt_v_i = 1'b0; tag_mem_pkt_v_i = 1'b0; stat_mem_pkt_v_i = 1'b0;
        data_pipe_busy_i = 1'b0; tag_pipe_busy_i = 1'b0; stat_pipe_busy_i = 1'b0;
    endtask

    // asynchronous reset: outputs must clear before any clock edge
    task automatic apply_reset();
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_req_v", 64'(cache_req_v_o), 64'd0);
        chk("rst_meta_v", 64'(cache_req_metadata_v_o), 64'd0);
        chk("rst_watchdog", 64'(watchdog_o), 64'd0);
        chk("rst_req_pkt", 64'(cache_req_o), 64'd0);
        chk("rst_data_mem", 64'(data_mem_o), 64'd0);
        model_reset();
        ctrl_idle();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0;
        ctrl_idle();
        randomize_payloads();
        model_reset();
        apply_reset();
        cycle();

        // miss with ready high, completion on the 9th cycle after the miss
        miss_v_i = 1'b1;
        cycle();
        miss_v_i = 1'b0;
        cache_req_ready_i = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cache_req_complete_i = (k == 9);
            cycle();
        end
        cache_req_complete_i = 1'b0;
        cycle();

        // ready withheld for five cycles after the miss
        cache_req_ready_i = 1'b0;
        miss_v_i = 1'b1;
        cycle();
        miss_v_i = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        cache_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        cache_req_complete_i = 1'b1;
        cycle();
        cache_req_complete_i = 1'b0;
        cache_req_ready_i = 1'b0;
        cycle();

        // data packet blocked for three cycles, granted in the fourth
        data_mem_pkt_v_i = 1'b1;
        data_pipe_busy_i = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        data_pipe_busy_i = 1'b0;
        cycle();
        data_mem_pkt_v_i = 1'b0;
        data_array_rdata_i = 32'hA5A5_A5A5;
        cycle();
        for (int k = 0; k < 10; k++) cycle();
        chk("data_hold", 64'(data_mem_o), 64'hA5A5_A5A5);

        // tag and stat together, only tag blocked
        tag_mem_pkt_v_i = 1'b1;
        stat_mem_pkt_v_i = 1'b1;
        tag_pipe_busy_i = 1'b1;
        cycle();
        stat_mem_pkt_v_i = 1'b0;
        cycle();
        tag_pipe_busy_i = 1'b0;
        cycle();
        tag_mem_pkt_v_i = 1'b0;
        for (int k = 0; k < 3; k++) cycle();

        // back-to-back data grants
        data_mem_pkt_v_i = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        data_mem_pkt_v_i = 1'b0;
        for (int k = 0; k < 2; k++) cycle();

        // watchdog: long WAIT, flag must survive the completion
        miss_v_i = 1'b1;
        cycle();
        miss_v_i = 1'b0;
        cache_req_ready_i = 1'b1;
        for (int k = 0; k < 14; k++) cycle();
        chk("wd_set", 64'(watchdog_o), 64'd1);
        cache_req_complete_i = 1'b1;
        cycle();
        cache_req_complete_i = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("wd_sticky", 64'(watchdog_o), 64'd1);

        // reset while waiting, then a normal miss
        miss_v_i = 1'b1;
        cycle();
        miss_v_i = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        cache_req_ready_i = 1'b1;
        apply_reset();
        cycle();
        miss_v_i = 1'b1;
        cache_req_ready_i = 1'b1;
        cycle();
        miss_v_i = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        cache_req_complete_i = 1'b1;
        cycle();
        cache_req_complete_i = 1'b0;
        cycle();

        // random phase
        for (int k = 0; k < 400; k++) begin
            miss_v_i             = ($urandom_range(0, 7) == 0);
            cache_req_ready_i    = ($urandom_range(0, 3) != 0);
            cache_req_complete_i = ($urandom_range(0, 5) == 0);
            data_mem_pkt_v_i     = 1'($urandom);
            tag_mem_pkt_v_i      = 1'($urandom);
            stat_mem_pkt_v_i     = 1'($urandom);
            data_pipe_busy_i     = 1'($urandom);
            tag_pipe_busy_i      = 1'($urandom);
            stat_pipe_busy_i     = 1'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
